// File: rtl/rtc_time_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_pkg
//  Description : Shared types, defaults and BCD range check for the RTC write path.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    localparam logic [7:0] DEF_ADDR_HOUR = 8'h04;
    localparam logic [7:0] DEF_ADDR_MIN  = 8'h02;
    localparam logic [7:0] DEF_ADDR_SEC  = 8'h00;

    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_PULSE = 4;
    localparam int DEF_T_HOLD  = 2;

    localparam logic [7:0] BCD_HOUR_MAX   = 8'h23;
    localparam logic [7:0] BCD_MINSEC_MAX = 8'h59;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_REQ   = 2'd1,
        SEQ_WRITE = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_t;

    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_A_SETUP  = 3'd1,
        PH_A_STROBE = 3'd2,
        PH_A_HOLD   = 3'd3,
        PH_D_SETUP  = 3'd4,
        PH_D_STROBE = 3'd5,
        PH_D_HOLD   = 3'd6,
        PH_GAP      = 3'd7
    } phase_t;

    // Both digits must be decimal and the packed value must not exceed max.
    function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_time_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_time_writer_if
//  Description : RTC multiplexed AD bus plus bus request/grant pair.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rtc_time_writer_if;
    logic       bus_req;
    logic       bus_gnt;
    logic       rtc_cs_n;
    logic       rtc_wr_n;
    logic       rtc_ale;
    logic       rtc_ad_oe;
    logic [7:0] rtc_ad_out;

    modport master (
        output bus_req, rtc_cs_n, rtc_wr_n, rtc_ale, rtc_ad_oe, rtc_ad_out,
        input  bus_gnt
    );

    modport slave (
        input  bus_req, rtc_cs_n, rtc_wr_n, rtc_ale, rtc_ad_oe, rtc_ad_out,
        output bus_gnt
    );
endinterface
`default_nettype wire

// File: rtl/rtc_wr_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_wr_cycle
//  Description : One address+data write on the RTC bus, followed by a CS-high gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_wr_cycle
    import rtc_pkg::*;
#(
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_HOLD  = DEF_T_HOLD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic       cycle_done,
    output logic       cs_n,
    output logic       wr_n,
    output logic       ale,
    output logic       ad_oe,
    output logic [7:0] ad_out
);

    localparam logic [3:0] C_SETUP = 4'(T_SETUP);
    localparam logic [3:0] C_PULSE = 4'(T_PULSE);
    localparam logic [3:0] C_HOLD  = 4'(T_HOLD);

    phase_t     r_phase, w_phase_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_addr, r_data;
    logic       w_last, w_load, w_addr_ph, w_data_ph;

    assign w_last     = (r_cnt == 4'd1);
    assign cycle_done = (r_phase == PH_GAP) && w_last;
    assign w_load     = start && ((r_phase == PH_IDLE) || cycle_done);
    assign w_addr_ph  = (r_phase == PH_A_SETUP) || (r_phase == PH_A_STROBE) || (r_phase == PH_A_HOLD);
    assign w_data_ph  = (r_phase == PH_D_SETUP) || (r_phase == PH_D_STROBE) || (r_phase == PH_D_HOLD);

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt - 4'd1;
        case (r_phase)
            PH_IDLE: begin
                w_cnt_nxt = 4'd0;
                if (start) begin
                    w_phase_nxt = PH_A_SETUP;
                    w_cnt_nxt   = C_SETUP;
                end
            end
            PH_A_SETUP:  if (w_last) begin w_phase_nxt = PH_A_STROBE; w_cnt_nxt = C_PULSE; end
            PH_A_STROBE: if (w_last) begin w_phase_nxt = PH_A_HOLD;   w_cnt_nxt = C_HOLD;  end
            PH_A_HOLD:   if (w_last) begin w_phase_nxt = PH_D_SETUP;  w_cnt_nxt = C_SETUP; end
            PH_D_SETUP:  if (w_last) begin w_phase_nxt = PH_D_STROBE; w_cnt_nxt = C_PULSE; end
            PH_D_STROBE: if (w_last) begin w_phase_nxt = PH_D_HOLD;   w_cnt_nxt = C_HOLD;  end
            PH_D_HOLD:   if (w_last) begin w_phase_nxt = PH_GAP;      w_cnt_nxt = C_HOLD;  end
            PH_GAP: begin
                // Back-to-back registers chain straight from the gap into the next address setup.
                if (w_last) begin
                    if (start) begin
                        w_phase_nxt = PH_A_SETUP;
                        w_cnt_nxt   = C_SETUP;
                    end else begin
                        w_phase_nxt = PH_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= PH_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 8'h00;
            r_data  <= 8'h00;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_addr <= addr;
                r_data <= data;
            end
        end
    end

    // Bus pins are registered copies of the current phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_n   <= 1'b1;
            wr_n   <= 1'b1;
            ale    <= 1'b0;
            ad_oe  <= 1'b0;
            ad_out <= 8'h00;
        end else begin
            cs_n   <= !(w_addr_ph || w_data_ph);
            ad_oe  <= w_addr_ph || w_data_ph;
            wr_n   <= !((r_phase == PH_A_STROBE) || (r_phase == PH_D_STROBE));
            ale    <= w_addr_ph;
            ad_out <= w_addr_ph ? r_addr : (w_data_ph ? r_data : 8'h00);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtc_time_writer.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_time_writer
//  Description : Validates a committed BCD time and writes hh/mm/ss to the RTC.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_time_writer
    import rtc_pkg::*;
#(
    parameter logic [7:0] ADDR_HOUR = DEF_ADDR_HOUR,
    parameter logic [7:0] ADDR_MIN  = DEF_ADDR_MIN,
    parameter logic [7:0] ADDR_SEC  = DEF_ADDR_SEC,
    parameter int         T_SETUP   = DEF_T_SETUP,
    parameter int         T_PULSE   = DEF_T_PULSE,
    parameter int         T_HOLD    = DEF_T_HOLD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit,
    input  logic [7:0]        hora_in,
    input  logic [7:0]        min_in,
    input  logic [7:0]        seg_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    rtc_time_writer_if.master bus
);

    seq_state_t r_state, w_state_nxt;
    logic [1:0] r_idx, w_sel;
    logic [7:0] r_hora, r_min, r_seg;
    logic [7:0] w_addr, w_data;
    logic       r_err_req, r_active;
    logic       w_start, w_commit_ok, w_accept, w_cycle_done;

    assign w_commit_ok = bcd_valid(hora_in, BCD_HOUR_MAX)
                      && bcd_valid(min_in, BCD_MINSEC_MAX)
                      && bcd_valid(seg_in, BCD_MINSEC_MAX);
    assign w_accept    = (r_state == SEQ_IDLE) && commit && w_commit_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_sel       = r_idx + 2'd1;
        case (r_state)
            SEQ_IDLE:  if (w_accept) w_state_nxt = SEQ_REQ;
            SEQ_REQ: begin
                // The grant is only looked at here; it is trusted until bus_req drops.
                if (bus.bus_gnt) begin
                    w_start     = 1'b1;
                    w_sel       = 2'd0;
                    w_state_nxt = SEQ_WRITE;
                end
            end
            SEQ_WRITE: begin
                if (w_cycle_done) begin
                    if (r_idx == 2'd2) w_state_nxt = SEQ_DONE;
                    else               w_start     = 1'b1;
                end
            end
            SEQ_DONE:  w_state_nxt = SEQ_IDLE;
        endcase
    end

    always_comb begin
        w_addr = ADDR_SEC;
        w_data = r_seg;
        case (w_sel)
            2'd0:    begin w_addr = ADDR_HOUR; w_data = r_hora; end
            2'd1:    begin w_addr = ADDR_MIN;  w_data = r_min;  end
            default: begin w_addr = ADDR_SEC;  w_data = r_seg;  end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= SEQ_IDLE;
            r_idx     <= 2'd0;
            r_hora    <= 8'h00;
            r_min     <= 8'h00;
            r_seg     <= 8'h00;
            r_err_req <= 1'b0;
            r_active  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_req <= (r_state == SEQ_IDLE) && commit && !w_commit_ok;
            if (w_accept) begin
                r_hora <= hora_in;
                r_min  <= min_in;
                r_seg  <= seg_in;
            end
            if (w_start) r_idx <= w_sel;
            // Status outputs trail the state by one register stage, matching the bus pins.
            r_active  <= (r_state == SEQ_REQ) || (r_state == SEQ_WRITE);
            done      <= (r_state == SEQ_DONE);
            err       <= r_err_req;
        end
    end

    assign busy        = r_active;
    assign bus.bus_req = r_active;

    rtc_wr_cycle #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD)
    ) u_wr_cycle (
        .clk        (clk),
        .reset      (reset),
        .start      (w_start),
        .addr       (w_addr),
        .data       (w_data),
        .cycle_done (w_cycle_done),
        .cs_n       (bus.rtc_cs_n),
        .wr_n       (bus.rtc_wr_n),
        .ale        (bus.rtc_ale),
        .ad_oe      (bus.rtc_ad_oe),
        .ad_out     (bus.rtc_ad_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_rtc_time_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_time_writer
//  Description : Scoreboard bench for rtc_time_writer (default and 1/1/1 timing).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_time_writer;

    localparam int          T_PULSE0 = 4;
    localparam logic [15:0] IDLE_VEC = 16'b0000_1100_0000_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       commit0 = 1'b0;
    logic       commit1 = 1'b0;
    logic       gnt = 1'b1;
    logic [7:0] hora = 8'h00, mins = 8'h00, segs = 8'h00;
    logic       busy0, done0, err0, busy1, done1, err1;
    logic [15:0] ov0, ov1;

    int n_vec = 0;
    int n_mis = 0;
    logic [15:0] exp_q[$];

    int first_busy, last_busy, busy_cnt, done_cyc, done_cnt, first_cs, err_cyc, err_cnt, req_cnt;

    rtc_time_writer_if b0();
    rtc_time_writer_if b1();
    assign b0.bus_gnt = gnt;
    assign b1.bus_gnt = 1'b1;

    rtc_time_writer u_dut (
        .clk(clk), .reset(reset), .commit(commit0),
        .hora_in(hora), .min_in(mins), .seg_in(segs),
        .busy(busy0), .done(done0), .err(err0), .bus(b0)
    );

    rtc_time_writer #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) u_fast (
        .clk(clk), .reset(reset), .commit(commit1),
        .hora_in(hora), .min_in(mins), .seg_in(segs),
        .busy(busy1), .done(done1), .err(err1), .bus(b1)
    );

    assign ov0 = {busy0, done0, err0, b0.bus_req, b0.rtc_cs_n, b0.rtc_wr_n, b0.rtc_ale, b0.rtc_ad_oe, b0.rtc_ad_out};
    assign ov1 = {busy1, done1, err1, b1.bus_req, b1.rtc_cs_n, b1.rtc_wr_n, b1.rtc_ale, b1.rtc_ad_oe, b1.rtc_ad_out};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push3(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        exp_q.push_back({8'h04, h});
        exp_q.push_back({8'h02, m});
        exp_q.push_back({8'h00, s});
    endtask

    // Commit is sampled by the posedge right after this task's negedge (cycle 0 follows).
    task automatic do_commit(input int which, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        @(negedge clk);
        hora = h; mins = m; segs = s;
        if (which == 0) commit0 = 1'b1; else commit1 = 1'b1;
        @(posedge clk);
        #1;
        commit0 = 1'b0;
        commit1 = 1'b0;
    endtask

    task automatic run_window(input int n, input int gnt_at, input int recommit_at);
        first_busy = -1; last_busy = -1; busy_cnt = 0; done_cyc = -1; done_cnt = 0;
        first_cs = -1; err_cyc = -1; err_cnt = 0; req_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (busy0) begin
                if (first_busy < 0) first_busy = k;
                last_busy = k;
                busy_cnt++;
            end
            if (done0) begin done_cnt++; if (done_cyc < 0) done_cyc = k; end
            if (err0)  begin err_cnt++;  if (err_cyc < 0)  err_cyc = k;  end
            if (!b0.rtc_cs_n && first_cs < 0) first_cs = k;
            if (b0.bus_req) req_cnt++;
            if (k == gnt_at) gnt = 1'b1;
            if (k == recommit_at) begin
                commit0 = 1'b1; hora = 8'h01; mins = 8'h02; segs = 8'h03;
            end else begin
                commit0 = 1'b0;
            end
        end
        commit0 = 1'b0;
    endtask

    // Bus monitor: reassembles (address, data) pairs from the strobes and scores them.
    initial begin
        logic        prev_wr, st_ale;
        logic [7:0]  st_val, last_addr;
        logic [15:0] e;
        int          low;
        prev_wr = 1'b1; st_ale = 1'b0; st_val = 8'h00; last_addr = 8'h00; low = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_wr = 1'b1;
                low     = 0;
            end else begin
                if (!b0.rtc_wr_n) begin
                    if (prev_wr) begin
                        st_ale = b0.rtc_ale;
                        st_val = b0.rtc_ad_out;
                        chk("strobe_cs_oe", {30'd0, b0.rtc_cs_n, b0.rtc_ad_oe}, 32'd1);
                    end
                    low++;
                end else if (!prev_wr) begin
                    chk("strobe_len", low, T_PULSE0);
                    low = 0;
                    if (st_ale) begin
                        last_addr = st_val;
                    end else begin
                        if (exp_q.size() > 0) e = exp_q.pop_front();
                        else                  e = 16'hxxxx;
                        chk("reg_write", {16'd0, last_addr, st_val}, {16'd0, e});
                    end
                end
                prev_wr = b0.rtc_wr_n;
            end
        end
    end

    initial begin
        int         low1, falls1, done1_cyc, na, nd;
        logic       prev1;
        logic [7:0] a_seen[3];
        logic [7:0] d_seen[3];

        repeat (3) @(negedge clk);
        chk("rst_idle", ov0, IDLE_VEC);
        chk("rst_idle_fast", ov1, IDLE_VEC);
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("quiet", ov0, IDLE_VEC);
        end

        // Valid commit, grant already high.
        push3(8'h23, 8'h59, 8'h58);
        do_commit(0, 8'h23, 8'h59, 8'h58);
        run_window(60, -1, -1);
        chk("first_busy", first_busy, 1);
        chk("last_busy", last_busy, 55);
        chk("busy_cnt", busy_cnt, 55);
        chk("req_cnt", req_cnt, 55);
        chk("first_cs", first_cs, 2);
        chk("done_cyc", done_cyc, 56);
        chk("done_cnt", done_cnt, 1);

        // Out-of-range hour and non-decimal minute are rejected.
        do_commit(0, 8'h24, 8'h00, 8'h00);
        run_window(6, -1, -1);
        chk("err_hour_cyc", err_cyc, 1);
        chk("err_hour_cnt", err_cnt, 1);
        chk("err_hour_cs", first_cs, -1);
        chk("err_hour_busy", busy_cnt, 0);
        do_commit(0, 8'h12, 8'h5A, 8'h00);
        run_window(6, -1, -1);
        chk("err_min_cyc", err_cyc, 1);
        chk("err_min_cnt", err_cnt, 1);
        chk("err_min_cs", first_cs, -1);
        chk("err_min_busy", busy_cnt, 0);

        // Delayed grant plus a stray commit mid-transaction.
        gnt = 1'b0;
        push3(8'h12, 8'h34, 8'h56);
        do_commit(0, 8'h12, 8'h34, 8'h56);
        run_window(72, 10, 20);
        chk("gnt_first_cs", first_cs, 12);
        chk("gnt_first_busy", first_busy, 1);
        chk("gnt_req_cnt", req_cnt, 65);
        chk("gnt_done_cyc", done_cyc, 66);
        chk("gnt_err_cnt", err_cnt, 0);

        // Asynchronous reset during the minutes data strobe.
        push3(8'h11, 8'h22, 8'h33);
        do_commit(0, 8'h11, 8'h22, 8'h33);
        for (int k = 0; k <= 31; k++) @(negedge clk);
        chk("pre_rst_dstrobe", {22'd0, b0.rtc_wr_n, b0.rtc_ale, b0.rtc_ad_out}, {22'd0, 2'b00, 8'h22});
        #2 reset = 1'b0;
        #1 chk("async_rst", ov0, IDLE_VEC);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst_q_left", exp_q.size(), 2);
        exp_q.delete();
        @(negedge clk);
        chk("post_rst", ov0, IDLE_VEC);
        push3(8'h00, 8'h00, 8'h00);
        do_commit(0, 8'h00, 8'h00, 8'h00);
        run_window(60, -1, -1);
        chk("zero_done_cyc", done_cyc, 56);
        chk("zero_first_cs", first_cs, 2);

        // Minimum-timing instance.
        low1 = 0; falls1 = 0; done1_cyc = -1; na = 0; nd = 0; prev1 = 1'b1;
        do_commit(1, 8'h09, 8'h30, 8'h15);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!b1.rtc_wr_n) begin
                low1++;
                if (prev1) falls1++;
                if (b1.rtc_ale) begin if (na < 3) a_seen[na] = b1.rtc_ad_out; na++; end
                else            begin if (nd < 3) d_seen[nd] = b1.rtc_ad_out; nd++; end
            end
            prev1 = b1.rtc_wr_n;
            if (done1 && done1_cyc < 0) done1_cyc = k;
        end
        chk("fast_low_cycles", low1, 6);
        chk("fast_strobes", falls1, 6);
        chk("fast_done_cyc", done1_cyc, 23);
        chk("fast_addr_cnt", na, 3);
        chk("fast_data_cnt", nd, 3);
        chk("fast_writes", {8'd0, a_seen[0], d_seen[0], a_seen[1]}, {8'd0, 8'h04, 8'h09, 8'h02});
        chk("fast_writes2", {d_seen[1], a_seen[2], d_seen[2], 8'd0}, {8'h30, 8'h00, 8'h15, 8'd0});

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_time_writer.md
# rtc_time_writer

Write-back engine for the clock-setting path: when the user commits an edited time, it latches the BCD hour/minute/second values held by the display counters, range-checks them, and writes them into the RTC over the shared multiplexed address/data bus. It is the write direction of the RTC interface. The existing read path loads the counters from RTC data while `enable` is low; this block returns the edited values to the RTC once editing ends. Bus ownership is arbitrated against the RTC reader through a request/grant pair.

## Interface
- `ADDR_HOUR`, default 8'h04: RTC hours register address.
- `ADDR_MIN`, default 8'h02: RTC minutes register address.
- `ADDR_SEC`, default 8'h00: RTC seconds register address.
- `T_SETUP`, default 2: cycles of address/data setup before the strobe, range 1..15.
- `T_PULSE`, default 4: cycles `rtc_wr_n` is held low, range 1..15.
- `T_HOLD`, default 2: cycles of hold after the strobe; also the inter-register gap with chip select deasserted. Range 1..15.

Ports:
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `commit` input 1: single-cycle request to write the current time.
- `hora_in` input 8: BCD hours.
- `min_in` input 8: BCD minutes.
- `seg_in` input 8: BCD seconds.
- `busy` output 1: a transaction is in progress.
- `done` output 1: one-cycle pulse when all three writes are complete.
- `err` output 1: one-cycle pulse when a commit is rejected.
- `bus_req` output 1: request for RTC bus ownership.
- `bus_gnt` input 1: grant from the arbiter.
- `rtc_cs_n` output 1: chip select, active low.
- `rtc_wr_n` output 1: write strobe, active low.
- `rtc_ale` output 1: high selects the address phase, low selects the data phase.
- `rtc_ad_oe` output 1: drive enable for the AD bus.
- `rtc_ad_out` output 8: address or data driven onto the bus.

## Operation
- Reset values: `busy`=0, `done`=0, `err`=0, `bus_req`=0, `rtc_cs_n`=1, `rtc_wr_n`=1, `rtc_ale`=0, `rtc_ad_oe`=0, `rtc_ad_out`=8'h00. State is IDLE.
- States:
  - IDLE
  - REQ
  - For each register, in order hours, minutes, seconds:
    - A_SETUP: `rtc_ale`=1, `rtc_ad_out`=address.
    - A_STROBE
    - A_HOLD
    - D_SETUP: `rtc_ale`=0, `rtc_ad_out`=data.
    - D_STROBE
    - D_HOLD
    - GAP: `rtc_cs_n`=1, `rtc_ad_oe`=0.
  - DONE
- `rtc_cs_n`=0 and `rtc_ad_oe`=1 from A_SETUP through D_HOLD.
- `rtc_wr_n`=0 only in the STROBE states.
- Commit validation happens in IDLE:
  - Every nibble must be ≤9.
  - `hora_in` ≤ 8'h23, `min_in` ≤ 8'h59, `seg_in` ≤ 8'h59.
  - Invalid: `err` pulses the next cycle, state stays IDLE, no bus activity.
  - Valid: all three inputs are latched and the block enters REQ.
- REQ: `bus_req`=1. The block waits indefinitely for `bus_gnt`=1.
- Once `bus_gnt` is sampled high, the grant is assumed held until `bus_req` falls. Later values of `bus_gnt` are ignored.
- `busy` is 1 in every state except IDLE and DONE. `bus_req` is 1 from REQ through the final GAP.
- DONE lasts one cycle: `done`=1, `busy`=0, `bus_req`=0, then the block returns to IDLE.
- `commit` is ignored in every state except IDLE. Latched data is never updated mid-transaction.
- A single 4-bit phase counter loads the duration of each phase and the state advances when it reaches 1.
- An asynchronous reset mid-transaction forces all outputs to their reset values immediately. The resulting truncated RTC write is accepted. After release the block is in IDLE with no pending commit.

## Timing
- Each register costs 2·(T_SETUP+T_PULSE+T_HOLD)+T_HOLD cycles, which is 18 with the defaults.
- With `bus_gnt` tied high:
  - A_SETUP of the hours register begins 2 cycles after the edge that samples `commit`.
  - `done` is asserted 2+3·18 = 56 cycles after that edge.
- `err` is asserted exactly 1 cycle after the edge that samples an invalid `commit`.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package `rtc_pkg` holds:
  - the state enumeration;
  - default register addresses;
  - default T_* constants;
  - the function `bcd_valid(value, max)`.
- Sub-module `rtc_wr_cycle` is the natural split. Interface:
  - inputs `start`, `addr[7:0]`, `data[7:0]`;
  - output `cycle_done`;
  - it contains the phase counter and the A_/D_/GAP phases.
- The top level sequences REQ, the three registers, and DONE.

## Test plan
- Reset low → all outputs at their reset values. Release reset, hold `commit`=0 for 20 cycles → no change.
- Commit 23:59:58 with `bus_gnt`=1 → three writes on the bus:
  - (04,23), (02,59), (00,58);
  - `rtc_wr_n` low for exactly 4 cycles per phase;
  - `done` at cycle 56;
  - `busy` high for cycles 1–55.
- Commit with hour 8'h24, then with minutes 8'h5A → `err` pulse at cycle 1 each time, `rtc_cs_n` stays 1, `busy` stays 0.
- `bus_gnt` held low for 10 cycles after commit → `bus_req` stays 1 with no bus activity. A_SETUP starts 1 cycle after `bus_gnt` rises. A second `commit` with different data mid-transaction does not change the written values.
- Reset asserted during D_STROBE of the minutes register → outputs go idle asynchronously. A later commit of 00:00:00 completes a full three-register sequence.
- Override T_PULSE=1, T_SETUP=1, T_HOLD=1 → `rtc_wr_n` is low for 1 cycle per phase and `done` arrives at 2+3·7 = 23 cycles.
